// File: rtl/edge_path_scheduler_pkg.sv
// Shared types and helpers for the edge-sensitive path scheduler.
package edge_path_scheduler_pkg;

   typedef enum logic {IDLE, WAIT} state_t;

   localparam int DLY_MIN = 1;

   // Counter reload for a transition toward value; the caller narrows it to CNT_W bits.
   function automatic int sel_dly(input logic value, input int rise, input int fall);
      return (value ? rise : fall) - DLY_MIN;
   endfunction

endpackage

// File: rtl/edge_path_event_det.sv
// Trigger event detector; EDGE_PATH_SCHEDULER_POSEDGE_ONLY_EN restricts events to rising trig.
module edge_path_event_det (
   input  logic clock,
   input  logic trig,
   output logic ev
);

   logic trig_q;

   // Loading trig during reset as well keeps reset release free of spurious events.
   always_ff @(posedge clock) begin
      trig_q <= trig;
   end

`ifdef EDGE_PATH_SCHEDULER_POSEDGE_ONLY_EN
   assign ev = trig & ~trig_q;
`else
   assign ev = trig ^ trig_q;
`endif

endmodule

// File: rtl/edge_path_scheduler.sv
// Inertial edge-path sequencer: trig events sample din, dout follows after RISE_DLY/FALL_DLY clocks.
// Optional macro EDGE_PATH_SCHEDULER_POSEDGE_ONLY_EN (see edge_path_event_det).
module edge_path_scheduler
   import edge_path_scheduler_pkg::*;
#(
   parameter int RISE_DLY = 10,
   parameter int FALL_DLY = 8,
   parameter int CNT_W    = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic trig,
   input  logic din,
   output logic dout,
   output logic busy,
   output logic drop
);

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               pend, pend_n;
   logic               dout_n, drop_n;
   logic               ev, commit, eff;

   edge_path_event_det u_event_det (
      .clock (clock),
      .trig  (trig),
      .ev    (ev)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         pend  <= 1'b0;
         dout  <= 1'b0;
         drop  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         pend  <= pend_n;
         dout  <= dout_n;
         drop  <= drop_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pend_n  = pend;
      dout_n  = dout;
      drop_n  = 1'b0;
      commit  = (state == WAIT) && (cnt == '0);
      // A commit on this edge makes pend the reference for a coincident event.
      eff     = commit ? pend : dout;
      case (state)
         IDLE: begin
            if (ev && (din != eff)) begin
               pend_n  = din;
               cnt_n   = CNT_W'(sel_dly(din, RISE_DLY, FALL_DLY));
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (commit) begin
               dout_n = pend;
               if (ev && (din != eff)) begin
                  pend_n = din;
                  cnt_n  = CNT_W'(sel_dly(din, RISE_DLY, FALL_DLY));
               end else begin
                  state_n = IDLE;
               end
            end else if (ev && (din != pend)) begin
               state_n = IDLE;
               drop_n  = 1'b1;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == WAIT);
   end

endmodule
